// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - edit controller for set-time / set-alarm modes
//
// Captures the running time (m_load) or stored alarm (m_alarm) on mode entry,
// edits one field at a time from the select/increment buttons and commits with
// a single wr_time / wr_alarm strobe on mode exit. An edit left idle for
// TIMEOUT cycles is abandoned (timeout_evt) without any write.
//
// Optional feature macro: CLK_SET_DEC_EN adds btn_dec and decrement editing.
//
// Ports:
//   m_clk, m_reset            clock, async active-high reset
//   m_load, m_alarm           mode bits from the mode FSM (alarm has priority)
//   btn_sel, btn_inc, btn_dec synchronized button levels (btn_dec optional)
//   cur_*, alm_*              running time / stored alarm (sec,min 6b; hour 5b)
//   edit_*                    working value being edited
//   field_sel                 0 = sec, 1 = min, 2 = hour
//   editing                   high while in an edit state
//   wr_time, wr_alarm         one-cycle commit strobes
//   timeout_evt               one-cycle pulse when an edit is abandoned

module clock_set_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       m_clk,
    input  logic       m_reset,
    input  logic       m_load,
    input  logic       m_alarm,
    input  logic       btn_sel,
    input  logic       btn_inc,
`ifdef CLK_SET_DEC_EN
    input  logic       btn_dec,
`endif
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    input  logic [5:0] alm_sec,
    input  logic [5:0] alm_min,
    input  logic [4:0] alm_hour,
    output logic [5:0] edit_sec,
    output logic [5:0] edit_min,
    output logic [4:0] edit_hour,
    output logic [1:0] field_sel,
    output logic       editing,
    output logic       wr_time,
    output logic       wr_alarm,
    output logic       timeout_evt
);

    typedef enum logic [2:0] {
        S_IDLE, S_EDIT_T, S_EDIT_A, S_COMMIT_T, S_COMMIT_A, S_WAIT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       sel_q, inc_q;
    logic [7:0] idle_cnt;
    logic       sel_p, inc_p, any_p, step_up, in_edit, expire;

    assign sel_p = btn_sel & ~sel_q;
    assign inc_p = btn_inc & ~inc_q;

`ifdef CLK_SET_DEC_EN
    logic dec_q, dec_p, step_dn;
    assign dec_p   = btn_dec & ~dec_q;
    // Increment and decrement in the same cycle cancel each other.
    assign step_up = inc_p & ~dec_p;
    assign step_dn = dec_p & ~inc_p;
    assign any_p   = sel_p | inc_p | dec_p;
`else
    assign step_up = inc_p;
    assign any_p   = sel_p | inc_p;
`endif

    assign in_edit = (state == S_EDIT_T) || (state == S_EDIT_A);
    assign expire  = in_edit && !any_p && (idle_cnt == TO_LAST);

    always_ff @(posedge m_clk or posedge m_reset) begin
        if (m_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Mode exit is tested before expiry so a late exit still commits.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (m_alarm)     state_nx = S_EDIT_A;
                else if (m_load) state_nx = S_EDIT_T;
            end
            S_EDIT_T: begin
                if (!m_load)     state_nx = S_COMMIT_T;
                else if (expire) state_nx = S_WAIT;
            end
            S_EDIT_A: begin
                if (!m_alarm)    state_nx = S_COMMIT_A;
                else if (expire) state_nx = S_WAIT;
            end
            S_COMMIT_T: state_nx = S_IDLE;
            S_COMMIT_A: state_nx = S_IDLE;
            S_WAIT: begin
                if (!m_load && !m_alarm) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge m_clk or posedge m_reset) begin
        if (m_reset) begin
            sel_q       <= 1'b0;
            inc_q       <= 1'b0;
`ifdef CLK_SET_DEC_EN
            dec_q       <= 1'b0;
`endif
            idle_cnt    <= 8'd0;
            edit_sec    <= 6'd0;
            edit_min    <= 6'd0;
            edit_hour   <= 5'd0;
            field_sel   <= 2'd0;
            editing     <= 1'b0;
            wr_time     <= 1'b0;
            wr_alarm    <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            sel_q       <= btn_sel;
            inc_q       <= btn_inc;
`ifdef CLK_SET_DEC_EN
            dec_q       <= btn_dec;
`endif
            editing     <= (state_nx == S_EDIT_T) || (state_nx == S_EDIT_A);
            wr_time     <= (state_nx == S_COMMIT_T);
            wr_alarm    <= (state_nx == S_COMMIT_A);
            timeout_evt <= in_edit && (state_nx == S_WAIT);

            if (state == S_IDLE && state_nx == S_EDIT_A) begin
                // Out-of-range captured fields are clamped to 0.
                edit_sec  <= (alm_sec  > 6'd59) ? 6'd0 : alm_sec;
                edit_min  <= (alm_min  > 6'd59) ? 6'd0 : alm_min;
                edit_hour <= (alm_hour > 5'd23) ? 5'd0 : alm_hour;
                field_sel <= 2'd0;
                idle_cnt  <= 8'd0;
            end else if (state == S_IDLE && state_nx == S_EDIT_T) begin
                edit_sec  <= (cur_sec  > 6'd59) ? 6'd0 : cur_sec;
                edit_min  <= (cur_min  > 6'd59) ? 6'd0 : cur_min;
                edit_hour <= (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                field_sel <= 2'd0;
                idle_cnt  <= 8'd0;
            end else if (in_edit) begin
                idle_cnt <= any_p ? 8'd0 : idle_cnt + 8'd1;
                // Select wins over a same-cycle increment/decrement.
                if (sel_p) begin
                    field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
                end else if (step_up) begin
                    case (field_sel)
                        2'd0: edit_sec  <= (edit_sec  == 6'd59) ? 6'd0 : edit_sec  + 6'd1;
                        2'd1: edit_min  <= (edit_min  == 6'd59) ? 6'd0 : edit_min  + 6'd1;
                        2'd2: edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
                        default: ;
                    endcase
`ifdef CLK_SET_DEC_EN
                end else if (step_dn) begin
                    case (field_sel)
                        2'd0: edit_sec  <= (edit_sec  == 6'd0) ? 6'd59 : edit_sec  - 6'd1;
                        2'd1: edit_min  <= (edit_min  == 6'd0) ? 6'd59 : edit_min  - 6'd1;
                        2'd2: edit_hour <= (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
                        default: ;
                    endcase
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    localparam int TO = 4;

    logic       m_clk = 1'b0;
    logic       m_reset, m_load, m_alarm, btn_sel, btn_inc, btn_dec;
    logic [5:0] cur_sec, cur_min, alm_sec, alm_min, edit_sec, edit_min;
    logic [4:0] cur_hour, alm_hour, edit_hour;
    logic [1:0] field_sel;
    logic       editing, wr_time, wr_alarm, timeout_evt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 editing, 2 committing, 3 waiting.
    int ph, kind, ms, mm, mh, mf, idle;
    bit ps, pi, pd, e_wt, e_wa, e_tev;

    clock_set_ctrl #(.TIMEOUT(TO)) dut (
        .m_clk(m_clk), .m_reset(m_reset), .m_load(m_load), .m_alarm(m_alarm),
        .btn_sel(btn_sel), .btn_inc(btn_inc),
`ifdef CLK_SET_DEC_EN
        .btn_dec(btn_dec),
`endif
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .alm_sec(alm_sec), .alm_min(alm_min), .alm_hour(alm_hour),
        .edit_sec(edit_sec), .edit_min(edit_min), .edit_hour(edit_hour),
        .field_sel(field_sel), .editing(editing), .wr_time(wr_time),
        .wr_alarm(wr_alarm), .timeout_evt(timeout_evt)
    );

    always #5 m_clk = ~m_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task model_reset();
        ph = 0; kind = 0; ms = 0; mm = 0; mh = 0; mf = 0; idle = 0;
        ps = 0; pi = 0; pd = 0; e_wt = 0; e_wa = 0; e_tev = 0;
    endtask

    task model_enter(input int k);
        ph = 1; kind = k; mf = 0; idle = 0;
        if (k == 1) begin
            ms = (alm_sec > 59) ? 0 : int'(alm_sec);
            mm = (alm_min > 59) ? 0 : int'(alm_min);
            mh = (alm_hour > 23) ? 0 : int'(alm_hour);
        end else begin
            ms = (cur_sec > 59) ? 0 : int'(cur_sec);
            mm = (cur_min > 59) ? 0 : int'(cur_min);
            mh = (cur_hour > 23) ? 0 : int'(cur_hour);
        end
    endtask

    task model_bump(input int delta);
        case (mf)
            0: ms = (ms + 60 + delta) % 60;
            1: mm = (mm + 60 + delta) % 60;
            default: mh = (mh + 24 + delta) % 24;
        endcase
    endtask

    task model_edge();
        bit sp, ip, dp, pressed, leave;
        sp = btn_sel && !ps;
        ip = btn_inc && !pi;
        dp = 0;
`ifdef CLK_SET_DEC_EN
        dp = btn_dec && !pd;
`endif
        pressed = sp || ip || dp;
        e_wt = 0; e_wa = 0; e_tev = 0;
        case (ph)
            0: begin
                if (m_alarm)     model_enter(1);
                else if (m_load) model_enter(0);
            end
            1: begin
                if (sp)             mf = (mf + 1) % 3;
                else if (ip && !dp) model_bump(1);
                else if (dp && !ip) model_bump(-1);
                leave = (kind == 1) ? !m_alarm : !m_load;
                if (leave) begin
                    ph = 2; e_wt = (kind == 0); e_wa = (kind == 1);
                end else if (!pressed && idle == TO - 1) begin
                    ph = 3; e_tev = 1;
                end
                idle = pressed ? 0 : idle + 1;
            end
            2: ph = 0;
            default: if (!m_load && !m_alarm) ph = 0;
        endcase
        ps = btn_sel; pi = btn_inc; pd = btn_dec;
    endtask

    task compare_all(input string tag);
        logic [16:0] e_edit;
        logic [5:0]  e_ctl;
        e_edit = {5'(mh), 6'(mm), 6'(ms)};
        e_ctl  = {2'(mf), (ph == 1), e_wt, e_wa, e_tev};
        chk({tag, "_edit"}, 32'({edit_hour, edit_min, edit_sec}), 32'(e_edit));
        chk({tag, "_ctl"}, 32'({field_sel, editing, wr_time, wr_alarm, timeout_evt}), 32'(e_ctl));
    endtask

    task step(input bit l, input bit a, input bit s, input bit i, input bit d);
        m_load = l; m_alarm = a; btn_sel = s; btn_inc = i; btn_dec = d;
        @(posedge m_clk);
        model_edge();
        #1;
        compare_all("step");
    endtask

    task do_reset();
        m_reset = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge m_clk);
        #1;
        compare_all("reset_held");
        m_reset = 1'b0;
    endtask

    task set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task set_alm(input int h, input int m, input int s);
        alm_hour = 5'(h); alm_min = 6'(m); alm_sec = 6'(s);
    endtask

    initial begin
        bit rl, ra;
        m_load = 0; m_alarm = 0; btn_sel = 0; btn_inc = 0; btn_dec = 0;
        set_cur(0, 0, 0); set_alm(0, 0, 0);
        #2;
        do_reset();

        // Set time with commit: 12:34:56 -> 12:36:00
        set_cur(12, 34, 56);
        step(1, 0, 0, 0, 0);
        chk("t1_entry", 32'({edit_hour, edit_min, edit_sec}), 32'({5'd12, 6'd34, 6'd56}));
        for (int k = 0; k < 4; k++) begin step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0); end
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0); end
        step(0, 0, 0, 0, 0);
        chk("t1_value", 32'({edit_hour, edit_min, edit_sec}), 32'({5'd12, 6'd36, 6'd0}));
        chk("t1_wr", 32'({wr_time, wr_alarm}), 32'(2'b10));
        step(0, 0, 0, 0, 0);
        chk("t1_wr_once", 32'(wr_time), 32'(0));

        // Mode handoff time -> alarm
        step(1, 0, 0, 0, 0);
        set_alm(7, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t2_wr_time", 32'(wr_time), 32'(1));
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t2_editing", 32'(editing), 32'(1));
        chk("t2_value", 32'({edit_hour, edit_min, edit_sec}), 32'({5'd7, 6'd0, 6'd0}));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Hour wrap and minute clamp
        set_alm(23, 61, 10);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); end
        step(0, 1, 0, 1, 0);
        chk("t3_hm", 32'({edit_hour, edit_min}), 32'({5'd0, 6'd0}));
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_wr_alarm", 32'({wr_alarm, wr_time}), 32'(2'b10));
        step(0, 0, 0, 0, 0);
        chk("t3_wr_once", 32'(wr_alarm), 32'(0));

        // Timeout after TO idle cycles
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < TO - 1; k++) step(1, 0, 0, 0, 0);
        chk("t4_still_edit", 32'({editing, timeout_evt}), 32'(2'b10));
        step(1, 0, 0, 0, 0);
        chk("t4_timeout", 32'({editing, timeout_evt}), 32'(2'b01));
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_no_wr", 32'(wr_time), 32'(0));
        step(0, 0, 0, 0, 0);

        // Simultaneous select+increment, then reset mid-edit
        set_cur(10, 20, 30);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("t5_sel", 32'({field_sel, edit_sec}), 32'({2'd1, 6'd30}));
        do_reset();
        chk("t5_after_reset", 32'({edit_hour, edit_min, edit_sec, field_sel, editing, wr_time, wr_alarm, timeout_evt}), 32'(0));
        step(0, 0, 0, 0, 0);
        chk("t5_no_strobe", 32'({wr_time, wr_alarm}), 32'(0));

`ifdef CLK_SET_DEC_EN
        set_cur(5, 5, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("t6_dec_wrap", 32'(edit_sec), 32'(59));
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
`endif

        // Randomized stimulus against the model
        rl = 0; ra = 0;
        for (int n = 0; n < 1500; n++) begin
            cur_sec = 6'($urandom); cur_min = 6'($urandom); cur_hour = 5'($urandom);
            alm_sec = 6'($urandom); alm_min = 6'($urandom); alm_hour = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rl = ~rl;
            if ($urandom_range(0, 9) == 0) ra = ~ra;
            if ($urandom_range(0, 249) == 0) do_reset();
            step(rl, ra, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
`ifdef CLK_SET_DEC_EN
                 $urandom_range(0, 3) == 0
`else
                 1'b0
`endif
            );
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
